// File: rtl/sips4_pkg.sv
// Shared definitions for the SIPS4 program-memory loader.
// Provides the default memory geometry, the nibble width and the loader state type.
package sips4_pkg;

    localparam int unsigned SIPS4_ADDR_W = 4;
    localparam int unsigned SIPS4_WORD_W = 16;
    localparam int unsigned SIPS4_NIB_W  = 4;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_COLLECT = 3'd1,
        LD_WRITE   = 3'd2,
        LD_FULL    = 3'd3,
        LD_EXIT    = 3'd4
    } ld_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability filter and press detector.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn_n_i     : raw active-low button, asynchronous and bouncy
//   press_o     : one-cycle pulse when the filtered level falls 1->0 (release gives nothing)
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Down-counter armed while the synchronized input agrees with the filtered level;
    // the filtered level follows only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            db_d  = sync2_q;
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        press_d = db_q & ~db_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q    <= 1'b1;
            cnt_q   <= RELOAD;
            press_q <= 1'b0;
        end else begin
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sips4_prog_loader.sv
// SIPS4 program-memory writer. Assembles four nibbles per instruction word from the
// slide switches (one per debounced button press, most significant nibble first),
// writes each word through a single memory write port and holds the core while loading.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   load_req               : level, 1 = enter/stay in load mode
//   nib_in                 : switch nibble, taken on an accepted press
//   strobe_n               : raw active-low button
//   wr_en/wr_addr/wr_data  : memory write port (wr_en is a one-cycle pulse)
//   cpu_hold, cpu_restart  : core control (restart pulses once when leaving load mode)
//   nib_idx, word_cnt, full: progress indicators for the board LEDs
//
// state      | meaning
// -----------+----------------------------------------------------------
// LD_IDLE    | core running; waiting for load_req
// LD_COLLECT | core held; accepting nibbles of the current word
// LD_WRITE   | single cycle; wr_en asserted, pointer and word count advance
// LD_FULL    | every address written this session; presses ignored
// LD_EXIT    | single cycle; cpu_restart with cpu_hold still asserted
module sips4_prog_loader
    import sips4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned ADDR_W          = SIPS4_ADDR_W,
    parameter int unsigned WORD_W          = SIPS4_WORD_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_req,
    input  logic [SIPS4_NIB_W-1:0] nib_in,
    input  logic                   strobe_n,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [WORD_W-1:0]      wr_data,
    output logic                   cpu_hold,
    output logic                   cpu_restart,
    output logic [1:0]             nib_idx,
    output logic [ADDR_W:0]        word_cnt,
    output logic                   full
);

    localparam int unsigned    NIBS     = WORD_W / SIPS4_NIB_W;
    localparam logic [1:0]     LAST_NIB = 2'(NIBS - 1);
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    ld_state_e                       state_q, state_d;
    logic [ADDR_W-1:0]               ptr_q, ptr_d;
    logic [WORD_W-SIPS4_NIB_W-1:0]   asm_q, asm_d;
    logic [WORD_W-1:0]               wr_data_q, wr_data_d;
    logic [1:0]                      nib_q, nib_d;
    logic [ADDR_W:0]                 cnt_q, cnt_d;
    logic                            full_q, full_d;
    logic                            press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n_i(strobe_n),
        .press_o(press)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        asm_d     = asm_q;
        wr_data_d = wr_data_q;
        nib_d     = nib_q;
        cnt_d     = cnt_q;
        full_d    = full_q;

        unique case (state_q)
            LD_IDLE: begin
                if (load_req) begin
                    state_d = LD_COLLECT;
                    ptr_d   = '0;
                    asm_d   = '0;
                    nib_d   = '0;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                end
            end
            LD_COLLECT: begin
                // Leaving load mode wins over a coincident press; the partial word is dropped.
                if (!load_req) begin
                    state_d = LD_EXIT;
                end else if (press) begin
                    if (nib_q == LAST_NIB) begin
                        wr_data_d = {asm_q, nib_in};
                        nib_d     = '0;
                        state_d   = LD_WRITE;
                    end else begin
                        asm_d = {asm_q[WORD_W-2*SIPS4_NIB_W-1:0], nib_in};
                        nib_d = nib_q + 2'd1;
                    end
                end
            end
            LD_WRITE: begin
                // The write is already on the port this cycle, so it completes even on exit.
                ptr_d = ptr_q + ADDR_W'(1);
                cnt_d = cnt_q + (ADDR_W+1)'(1);
                if (cnt_d == DEPTH) begin
                    full_d = 1'b1;
                end
                if (!load_req) begin
                    state_d = LD_EXIT;
                end else if (cnt_d == DEPTH) begin
                    state_d = LD_FULL;
                end else begin
                    state_d = LD_COLLECT;
                end
            end
            LD_FULL: begin
                if (!load_req) begin
                    state_d = LD_EXIT;
                end
            end
            LD_EXIT: begin
                state_d = LD_IDLE;
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LD_IDLE;
            ptr_q     <= '0;
            asm_q     <= '0;
            wr_data_q <= '0;
            nib_q     <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            asm_q     <= asm_d;
            wr_data_q <= wr_data_d;
            nib_q     <= nib_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
        end
    end

    // The write address is the pointer itself: during LD_WRITE it still holds the
    // target address, and after the last write it has wrapped back to 0.
    assign wr_en       = (state_q == LD_WRITE);
    assign wr_addr     = ptr_q;
    assign wr_data     = wr_data_q;
    assign cpu_hold    = (state_q != LD_IDLE);
    assign cpu_restart = (state_q == LD_EXIT);
    assign nib_idx     = nib_q;
    assign word_cnt    = cnt_q;
    assign full        = full_q;

endmodule

// File: tb/tb_sips4_prog_loader.sv
module tb_sips4_prog_loader;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [3:0]  nib_in = 4'h0;
    logic        strobe_n = 1'b1;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        cpu_restart;
    logic [1:0]  nib_idx;
    logic [4:0]  word_cnt;
    logic        full;

    always #5 clk = ~clk;

    sips4_prog_loader #(
        .DEBOUNCE_CYCLES(D),
        .ADDR_W         (4),
        .WORD_W         (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .nib_in     (nib_in),
        .strobe_n   (strobe_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .cpu_restart(cpu_restart),
        .nib_idx    (nib_idx),
        .word_cnt   (word_cnt),
        .full       (full)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr = 0, n_restart = 0, n_overlap_bad = 0;
    logic [15:0] dut_mem[16];
    logic [15:0] exp_mem[16];

    // Behavioural reference: session phase, queue of accepted nibbles, pointer, counters.
    typedef enum {P_IDLE, P_LOAD, P_WRITE, P_FULL, P_EXIT} phase_t;
    phase_t      ph;
    logic [3:0]  nibq[$];
    int          m_ptr, m_cnt;
    bit          m_full;
    logic [15:0] m_data;
    bit          m_db;
    bit          m_press_pend;
    bit          hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE;
        nibq.delete();
        m_ptr = 0; m_cnt = 0; m_full = 0; m_data = 16'h0;
        m_db = 1; m_press_pend = 0;
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(1'b1);
    endtask

    task automatic model_step();
        bit press_use;
        bit all_new;
        press_use = m_press_pend;
        case (ph)
            P_IDLE: if (load_req) begin
                ph = P_LOAD; nibq.delete(); m_ptr = 0; m_cnt = 0; m_full = 0;
            end
            P_LOAD: begin
                if (!load_req) ph = P_EXIT;
                else if (press_use) begin
                    nibq.push_back(nib_in);
                    if (nibq.size() == 4) begin
                        m_data = 16'(nibq[0]) * 16'h1000 + 16'(nibq[1]) * 16'h0100
                               + 16'(nibq[2]) * 16'h0010 + 16'(nibq[3]);
                        nibq.delete();
                        ph = P_WRITE;
                    end
                end
            end
            P_WRITE: begin
                exp_mem[m_ptr] = m_data;
                m_ptr = (m_ptr + 1) % 16;
                m_cnt = m_cnt + 1;
                m_full = (m_cnt == 16);
                if (!load_req) ph = P_EXIT;
                else if (m_cnt == 16) ph = P_FULL;
                else ph = P_LOAD;
            end
            P_FULL: if (!load_req) ph = P_EXIT;
            default: ph = P_IDLE;
        endcase
        // Button filter: the level follows the input once the synchronized value
        // (two samples old) has differed from it for D consecutive cycles.
        hist.push_front(strobe_n);
        void'(hist.pop_back());
        all_new = 1;
        for (int i = 2; i < D + 2; i++) if (hist[i] == m_db) all_new = 0;
        m_press_pend = 0;
        if (all_new) begin
            m_press_pend = m_db;
            m_db = ~m_db;
        end
    endtask

    task automatic compare_all();
        check("wr_en",       32'(wr_en),       32'(ph == P_WRITE));
        check("wr_addr",     32'(wr_addr),     32'(m_ptr));
        check("wr_data",     32'(wr_data),     32'(m_data));
        check("cpu_hold",    32'(cpu_hold),    32'(ph != P_IDLE));
        check("cpu_restart", 32'(cpu_restart), 32'(ph == P_EXIT));
        check("nib_idx",     32'(nib_idx),     32'(nibq.size()));
        check("word_cnt",    32'(word_cnt),    32'(m_cnt));
        check("full",        32'(full),        32'(m_full));
        if (wr_en === 1'b1) begin
            dut_mem[wr_addr] = wr_data;
            n_wr++;
        end
        if (cpu_restart === 1'b1) n_restart++;
        if (cpu_restart === 1'b1 && cpu_hold !== 1'b1) n_overlap_bad++;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
    end

    task automatic press(input logic [3:0] n);
        @(negedge clk);
        nib_in = n; strobe_n = 1'b0;
        repeat (D + 6) @(negedge clk);
        strobe_n = 1'b1;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic bounce_press(input logic [3:0] n);
        @(negedge clk); nib_in = n; strobe_n = 1'b0;
        @(negedge clk); strobe_n = 1'b1;
        @(negedge clk); strobe_n = 1'b0;
        repeat (10) @(negedge clk);
        strobe_n = 1'b1;
        repeat (D + 6) @(negedge clk);
    endtask

    int w0, r0;
    bit found;

    initial begin
        for (int i = 0; i < 16; i++) begin dut_mem[i] = 16'h0; exp_mem[i] = 16'h0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-COLLECT with two nibbles taken
        @(negedge clk); load_req = 1'b1;
        press(4'h1); press(4'h2);
        check("pre_reset_nib_idx", 32'(nib_idx), 32'd2);
        @(posedge clk); #3;
        rst_n = 1'b0; load_req = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_hold", 32'(cpu_hold), 0);
        check("rst_restart", 32'(cpu_restart), 0);
        check("rst_nib_idx", 32'(nib_idx), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        check("rst_full", 32'(full), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_write_after_reset", 32'(n_wr), 0);

        // Single word 0x1234
        w0 = n_wr;
        load_req = 1'b1;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("single_writes", 32'(n_wr - w0), 1);
        check("single_word", 32'(dut_mem[0]), 32'h1234);
        check("single_cnt", 32'(word_cnt), 1);

        // Bouncy press counts once
        bounce_press(4'h5);
        check("bounce_nib_idx", 32'(nib_idx), 1);

        // Exit after two nibbles
        press(4'h6);
        w0 = n_wr; r0 = n_restart;
        @(negedge clk); load_req = 1'b0;
        repeat (6) @(negedge clk);
        check("exit_restart_pulses", 32'(n_restart - r0), 1);
        check("exit_no_write", 32'(n_wr - w0), 0);
        check("exit_hold_released", 32'(cpu_hold), 0);

        // Full memory
        w0 = n_wr;
        load_req = 1'b1;
        for (int i = 0; i < 64; i++) press(4'(i >> 2));
        check("full_writes", 32'(n_wr - w0), 16);
        check("full_flag", 32'(full), 1);
        check("full_cnt", 32'(word_cnt), 16);
        for (int a = 0; a < 16; a++) check("full_word", 32'(dut_mem[a]), 32'({4{4'(a)}}));
        w0 = n_wr;
        press(4'h7);
        check("press65_no_write", 32'(n_wr - w0), 0);
        check("press65_addr", 32'(wr_addr), 0);
        @(negedge clk); load_req = 1'b0;
        repeat (4) @(negedge clk);
        check("full_held_idle", 32'(full), 1);

        // load_req falls in the WRITE cycle
        w0 = n_wr; r0 = n_restart;
        load_req = 1'b1;
        press(4'hA); press(4'hB); press(4'hC);
        @(negedge clk); nib_in = 4'hD; strobe_n = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (ph == P_WRITE) begin found = 1; break; end
        end
        check("wait_write_cycle", 32'(found), 1);
        load_req = 1'b0;
        repeat (D + 6) @(negedge clk);
        strobe_n = 1'b1;
        repeat (D + 6) @(negedge clk);
        check("wexit_writes", 32'(n_wr - w0), 1);
        check("wexit_word", 32'(dut_mem[0]), 32'hABCD);
        check("wexit_restart", 32'(n_restart - r0), 1);

        // Press coinciding with load_req falling
        load_req = 1'b1;
        press(4'h3);
        w0 = n_wr; r0 = n_restart;
        @(negedge clk); nib_in = 4'h9; strobe_n = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (m_press_pend) begin found = 1; break; end
        end
        check("wait_press_pulse", 32'(found), 1);
        load_req = 1'b0;
        repeat (D + 6) @(negedge clk);
        strobe_n = 1'b1;
        repeat (D + 6) @(negedge clk);
        check("simul_nib_idx", 32'(nib_idx), 1);
        check("simul_restart", 32'(n_restart - r0), 1);
        check("simul_no_write", 32'(n_wr - w0), 0);

        // Randomized bouncing button and load_req activity
        load_req = 1'b1;
        for (int s = 0; s < 400; s++) begin
            @(negedge clk);
            strobe_n = 1'($urandom_range(0, 1));
            nib_in = 4'($urandom);
            if ($urandom_range(0, 11) == 0) load_req = ~load_req;
            repeat ($urandom_range(0, 11)) @(negedge clk);
        end
        strobe_n = 1'b1; load_req = 1'b0;
        repeat (20) @(negedge clk);

        for (int a = 0; a < 16; a++) check("mem_image", 32'(dut_mem[a]), 32'(exp_mem[a]));
        check("restart_overlap", 32'(n_overlap_bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
